rename_unit_ckpt: RTL and testbench

//  Parametrised rename stage: speculative RAT, committed (retirement) RAT and circular free list with recovery.

---
 rtl/rename_unit_ckpt.sv | 98 +++++++++
 tb/tb_rename_unit_ckpt.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rename_unit_ckpt.sv
// rename_unit_ckpt: speculative/committed RAT rename stage with circular free list and one-cycle flush recovery
module rename_unit_ckpt #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = $clog2(PHYS_REGS),
  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rn_valid,
  output logic          rn_ready,
  input  logic [AW-1:0] rn_src1,
  input  logic [AW-1:0] rn_src2,
  input  logic [AW-1:0] rn_dest,
  input  logic          rn_has_dest,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_src1,
  output logic [PW-1:0] out_src2,
  output logic [PW-1:0] out_dest,
  output logic [PW-1:0] out_dest_old,
  input  logic          cm_valid,
  input  logic          cm_has_dest,
  input  logic [AW-1:0] cm_arch_dest,
  input  logic [PW-1:0] cm_phys_dest,
  input  logic [PW-1:0] cm_phys_old,
  input  logic          flush,
  output logic [PW:0]   free_count
);
  localparam int FW = FL_DEPTH > 1 ? $clog2(FL_DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(FL_DEPTH);
  logic [PW-1:0] spec_rat [ARCH_REGS];
  logic [PW-1:0] com_rat [ARCH_REGS];
  logic [PW-1:0] com_nx [ARCH_REGS];
  logic [PW-1:0] fl [FL_DEPTH];
  logic [FW-1:0] head, tail, ret_head, ret_nx;
  logic fire, alloc, cm_req, cm_err, cm_ok;
  function automatic logic [FW-1:0] inc(input logic [FW-1:0] p);
    return p == FW'(FL_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign rn_ready = !flush && free_count != 0 && (!out_valid || out_ready);
  assign fire = rn_valid && rn_ready;
  assign alloc = fire && rn_has_dest && rn_dest != 0;
  assign cm_req = cm_valid && cm_has_dest && cm_arch_dest != 0;
  assign cm_err = cm_req && free_count == FULL;
  assign cm_ok = cm_req && !cm_err;
  assign ret_nx = cm_ok ? inc(ret_head) : ret_head;
  always_comb begin
    com_nx = com_rat;
    if (cm_ok) com_nx[cm_arch_dest] = cm_phys_dest;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_rat[i] <= PW'(i);
        com_rat[i] <= PW'(i);
      end
      for (int k = 0; k < FL_DEPTH; k++) fl[k] <= PW'(ARCH_REGS + k);
      head <= '0;
      tail <= '0;
      ret_head <= '0;
      free_count <= FULL;
      out_valid <= 1'b0;
      out_src1 <= '0;
      out_src2 <= '0;
      out_dest <= '0;
      out_dest_old <= '0;
    end else begin
      assert (!cm_err);
      com_rat <= com_nx;
      ret_head <= ret_nx;
      if (cm_ok) begin
        fl[tail] <= cm_phys_old;
        tail <= inc(tail);
      end
      if (flush) begin
        spec_rat <= com_nx;
        head <= ret_nx;
        free_count <= FULL;
        out_valid <= 1'b0;
      end else begin
        free_count <= free_count - (PW+1)'(alloc) + (PW+1)'(cm_ok);
        if (alloc) begin
          spec_rat[rn_dest] <= fl[head];
          head <= inc(head);
        end
        if (fire) begin
          out_valid <= 1'b1;
          out_src1 <= spec_rat[rn_src1];
          out_src2 <= spec_rat[rn_src2];
          out_dest <= alloc ? fl[head] : '0;
          out_dest_old <= alloc ? spec_rat[rn_dest] : '0;
        end else if (out_ready) out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rename_unit_ckpt.sv
// tb_rename_unit_ckpt: directed self-checking bench for rename_unit_ckpt
module tb_rename_unit_ckpt;
  logic clk = 1'b0;
  logic reset, rn_valid, rn_ready, rn_has_dest, out_valid, out_ready;
  logic cm_valid, cm_has_dest, flush;
  logic [4:0] rn_src1, rn_src2, rn_dest, cm_arch_dest;
  logic [5:0] out_src1, out_src2, out_dest, out_dest_old, cm_phys_dest, cm_phys_old;
  logic [6:0] free_count;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  rename_unit_ckpt dut (
    .clk(clk), .reset(reset), .rn_valid(rn_valid), .rn_ready(rn_ready),
    .rn_src1(rn_src1), .rn_src2(rn_src2), .rn_dest(rn_dest), .rn_has_dest(rn_has_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_src1(out_src1), .out_src2(out_src2),
    .out_dest(out_dest), .out_dest_old(out_dest_old), .cm_valid(cm_valid),
    .cm_has_dest(cm_has_dest), .cm_arch_dest(cm_arch_dest), .cm_phys_dest(cm_phys_dest),
    .cm_phys_old(cm_phys_old), .flush(flush), .free_count(free_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic ren(input int s1, input int s2, input int d, input bit hd);
    rn_valid = 1'b1;
    rn_src1 = 5'(s1);
    rn_src2 = 5'(s2);
    rn_dest = 5'(d);
    rn_has_dest = hd;
  endtask
  task automatic cm(input int a, input int pd, input int po);
    cm_valid = 1'b1;
    cm_has_dest = 1'b1;
    cm_arch_dest = 5'(a);
    cm_phys_dest = 6'(pd);
    cm_phys_old = 6'(po);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    step;
    step;
    reset = 1'b0;
  endtask
  initial begin
    {rn_valid, rn_has_dest, cm_valid, cm_has_dest, flush} = '0;
    {rn_src1, rn_src2, rn_dest, cm_arch_dest, cm_phys_dest, cm_phys_old} = '0;
    out_ready = 1'b1;
    do_reset;
    chk("rst_count", free_count, 32);
    chk("rst_valid", out_valid, 0);
    chk("rst_dest", out_dest, 0);
    chk("rst_ready", rn_ready, 1);
    ren(2, 3, 1, 1);
    step;
    chk("r1_valid", out_valid, 1);
    chk("r1_src1", out_src1, 2);
    chk("r1_src2", out_src2, 3);
    chk("r1_dest", out_dest, 32);
    chk("r1_old", out_dest_old, 1);
    chk("r1_count", free_count, 31);
    ren(1, 1, 4, 1);
    step;
    chk("dep_src1", out_src1, 32);
    chk("dep_src2", out_src2, 32);
    chk("dep_dest", out_dest, 33);
    chk("dep_old", out_dest_old, 4);
    chk("dep_count", free_count, 30);
    ren(0, 1, 0, 1);
    step;
    chk("z_dest", out_dest, 0);
    chk("z_old", out_dest_old, 0);
    chk("z_src1", out_src1, 0);
    chk("z_src2", out_src2, 32);
    chk("z_count", free_count, 30);
    ren(1, 4, 7, 1);
    step;
    chk("r7_dest", out_dest, 34);
    chk("r7_old", out_dest_old, 7);
    out_ready = 1'b0;
    ren(7, 7, 8, 1);
    #1;
    chk("hold_ready", rn_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("hold_valid", out_valid, 1);
      chk("hold_dest", out_dest, 34);
      chk("hold_src2", out_src2, 33);
      chk("hold_count", free_count, 29);
    end
    out_ready = 1'b1;
    rn_valid = 1'b0;
    step;
    chk("drain_valid", out_valid, 0);
    do_reset;
    for (int i = 0; i < 32; i++) begin
      ren(0, 0, (i % 31) + 1, 1);
      step;
    end
    chk("ex_dest", out_dest, 63);
    chk("ex_count", free_count, 0);
    chk("ex_ready", rn_ready, 0);
    ren(0, 0, 2, 1);
    cm(1, 32, 1);
    step;
    cm_valid = 1'b0;
    chk("ex_cm_count", free_count, 1);
    chk("ex_cm_ready", rn_ready, 1);
    step;
    chk("ex_re_dest", out_dest, 1);
    chk("ex_re_old", out_dest_old, 33);
    chk("ex_re_count", free_count, 0);
    rn_valid = 1'b0;
    cm(1, 63, 32);
    step;
    chk("one_count", free_count, 1);
    ren(0, 0, 3, 1);
    cm(2, 1, 33);
    step;
    cm_valid = 1'b0;
    chk("same_dest", out_dest, 32);
    chk("same_count", free_count, 1);
    ren(0, 0, 4, 1);
    step;
    rn_valid = 1'b0;
    chk("next_dest", out_dest, 33);
    chk("next_count", free_count, 0);
    do_reset;
    ren(0, 0, 5, 1);
    step;
    chk("f1_dest", out_dest, 32);
    ren(5, 0, 5, 1);
    step;
    chk("f2_dest", out_dest, 33);
    chk("f2_old", out_dest_old, 32);
    rn_valid = 1'b0;
    cm(5, 32, 5);
    flush = 1'b1;
    step;
    cm_valid = 1'b0;
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_count", free_count, 32);
    ren(5, 0, 6, 1);
    step;
    chk("fl_src1", out_src1, 32);
    chk("fl_dest", out_dest, 33);
    chk("fl_count2", free_count, 31);
    ren(5, 6, 9, 1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    rn_valid = 1'b0;
    chk("mr_count", free_count, 32);
    chk("mr_valid", out_valid, 0);
    ren(5, 6, 1, 1);
    step;
    rn_valid = 1'b0;
    chk("mr_src1", out_src1, 5);
    chk("mr_src2", out_src2, 6);
    chk("mr_dest", out_dest, 32);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
